// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: PC register link, instruction memory request and
// response channels, redirect input and decode-side output channel.
interface fetch_unit_if;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    // The fetch unit itself.
    modport master (
        input  pc_cur,
        output pc_next,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_target,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_instr
    );

    // The surroundings: PC register, instruction memory, branch unit, decode.
    modport slave (
        output pc_cur,
        input  pc_next,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_target,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues in-order word requests at pc_cur, pairs
// each returned word with the PC it was fetched from, and buffers the pairs
// in a small FIFO toward decode. A redirect flushes the FIFO and marks every
// request still in flight as stale so its response is silently dropped.
module fetch_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + MAX_OUT + 1);
    localparam logic [CW-1:0] FIFO_DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_OUT_C    = CW'(MAX_OUT);
    localparam logic [IW-1:0] IQ_LAST      = IW'(MAX_OUT - 1);

    // In-flight queue depth need not be a power of two, so wrap explicitly.
    function automatic logic [IW-1:0] iq_inc(input logic [IW-1:0] p);
        return (p == IQ_LAST) ? '0 : p + IW'(1);
    endfunction

    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_instr_d [FIFO_DEPTH];
    logic [31:0]   iq_pc_q      [MAX_OUT];
    logic [31:0]   iq_pc_d      [MAX_OUT];
    logic [FW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [IW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] inflight_cnt_q, inflight_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] outstanding;
    logic          can_issue, issue_fire, rsp_keep, rsp_drop, if_pop, if_vld;

    // Issue gating reserves a FIFO slot for every request in flight, so
    // neither the FIFO nor the in-flight queue can overflow.
    always_comb begin
        outstanding = inflight_cnt_q + drop_cnt_q;
        can_issue   = !bus.redirect_valid && (outstanding < MAX_OUT_C)
                      && ((inflight_cnt_q + fifo_cnt_q) < FIFO_DEPTH_C);
        issue_fire  = can_issue && bus.imem_req_ready;
        rsp_keep    = bus.imem_rsp_valid && (drop_cnt_q == '0);
        rsp_drop    = bus.imem_rsp_valid && (drop_cnt_q != '0);
        if_vld      = (fifo_cnt_q != '0) && !bus.redirect_valid;
        if_pop      = if_vld && bus.if_ready;
    end

    // Outputs toward memory, PC register and decode; all forced idle in reset.
    always_comb begin
        bus.imem_req_valid = !reset && can_issue;
        bus.imem_req_addr  = bus.pc_cur & 32'hFFFF_FFFC;
        bus.if_valid       = !reset && if_vld;
        bus.if_pc          = fifo_pc_q[f_rd_q];
        bus.if_instr       = fifo_instr_q[f_rd_q];
        if (reset)
            bus.pc_next = 32'h0;
        else if (bus.redirect_valid)
            bus.pc_next = bus.redirect_target & 32'hFFFF_FFFC;
        else if (issue_fire)
            bus.pc_next = bus.pc_cur + 32'd4;
        else
            bus.pc_next = bus.pc_cur;
    end

    // Next-state for queues and counters; a redirect overrides everything.
    always_comb begin
        fifo_pc_d      = fifo_pc_q;
        fifo_instr_d   = fifo_instr_q;
        iq_pc_d        = iq_pc_q;
        f_wr_d         = f_wr_q;
        f_rd_d         = f_rd_q;
        iq_wr_d        = iq_wr_q;
        iq_rd_d        = iq_rd_q;
        fifo_cnt_d     = fifo_cnt_q;
        inflight_cnt_d = inflight_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        if (bus.redirect_valid) begin
            fifo_cnt_d     = '0;
            f_wr_d         = f_rd_q;
            inflight_cnt_d = '0;
            iq_wr_d        = iq_rd_q;
            drop_cnt_d     = outstanding - CW'(bus.imem_rsp_valid);
        end else begin
            if (issue_fire) begin
                iq_pc_d[iq_wr_q] = bus.pc_cur;
                iq_wr_d          = iq_inc(iq_wr_q);
            end
            if (rsp_keep) begin
                fifo_pc_d[f_wr_q]    = iq_pc_q[iq_rd_q];
                fifo_instr_d[f_wr_q] = bus.imem_rsp_data;
                f_wr_d               = f_wr_q + FW'(1);
                iq_rd_d              = iq_inc(iq_rd_q);
            end
            if (rsp_drop)
                drop_cnt_d = drop_cnt_q - CW'(1);
            if (if_pop)
                f_rd_d = f_rd_q + FW'(1);
            inflight_cnt_d = inflight_cnt_q + CW'(issue_fire) - CW'(rsp_keep);
            fifo_cnt_d     = fifo_cnt_q + CW'(rsp_keep) - CW'(if_pop);
        end
    end

    // Control state, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_wr_q         <= '0;
            f_rd_q         <= '0;
            iq_wr_q        <= '0;
            iq_rd_q        <= '0;
            fifo_cnt_q     <= '0;
            inflight_cnt_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            f_wr_q         <= f_wr_d;
            f_rd_q         <= f_rd_d;
            iq_wr_q        <= iq_wr_d;
            iq_rd_q        <= iq_rd_d;
            fifo_cnt_q     <= fifo_cnt_d;
            inflight_cnt_q <= inflight_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Payload storage; contents are meaningless until a counter covers them.
    always_ff @(posedge clk) begin
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
        iq_pc_q      <= iq_pc_d;
    end

    // A response with nothing outstanding would underflow drop_cnt or the queue.
    always_ff @(posedge clk) begin
        if (!reset && bus.imem_rsp_valid)
            assert (outstanding != '0);
    end
endmodule
